bist_signature_engine: RTL

- Self-test harness for generated combinational benchmark circuits.
- Drives an LFSR pseudo-random pattern stream into an external circuit-under-test (CUT).
- Compacts the CUT's response into a multiple-input signature register (MISR) and compares it against a golden signature.
- Parametrised in input/output width, CUT latency and polynomials, so one engine serves every generated circuit in the dataset flow.

---
 rtl/bist_signature_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bist_signature_engine.sv
// BIST harness: LFSR pattern generator feeding an external CUT, MISR response compaction,
// and a golden-signature comparison at the end of each run.
module bist_signature_engine #(
  parameter int unsigned N_IN     = 21,
  parameter int unsigned N_OUT    = 26,
  parameter logic [N_IN-1:0]  LFSR_POLY = N_IN'(21'h000005),
  parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(26'h0000047),
  parameter int unsigned RESP_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N_IN-1:0]  seed,
  input  logic [N_OUT-1:0] expected,
  output logic [N_IN-1:0]  pat_out,
  output logic             pat_valid,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic             pass
);

  localparam int unsigned PIPE_W  = (RESP_LAT > 0) ? RESP_LAT : 1;
  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    lfsr_q, lfsr_d;
  logic [N_OUT-1:0]   misr_q, misr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [PIPE_W-1:0]  vpipe_q, vpipe_d;
  logic               pass_q, pass_d;
  logic               resp_valid;
  logic [N_IN-1:0]    lfsr_step;
  logic [N_OUT-1:0]   misr_step;

  assign pat_valid = (state_q == StRun);
  assign pat_out   = pat_valid ? lfsr_q : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign signature = misr_q;
  // The final MISR value is already registered in DONE, so pass is valid during the pulse itself.
  assign pass      = done ? (misr_q == expected) : pass_q;

  assign resp_valid = (RESP_LAT == 0) ? pat_valid : vpipe_q[PIPE_W-1];

  assign lfsr_step = {lfsr_q[N_IN-2:0], 1'b0} ^ (lfsr_q[N_IN-1] ? LFSR_POLY : '0);
  assign misr_step = {misr_q[N_OUT-2:0], 1'b0} ^ (misr_q[N_OUT-1] ? MISR_POLY : '0) ^ resp_in;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = resp_valid ? misr_step : misr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    pass_d  = pass_q;
    vpipe_d = vpipe_q << 1;
    vpipe_d[0] = pat_valid;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          misr_d = '0;
          pass_d = 1'b0;
          if (num_patterns != '0) begin
            lfsr_d  = (seed == '0) ? '1 : seed;
            cnt_d   = num_patterns;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (RESP_LAT == 0) begin
            state_d = StDone;
          end else begin
            state_d = StDrain;
            drain_d = DRAIN_W'(RESP_LAT - 1);
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) state_d = StDone;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      StDone: begin
        pass_d  = (misr_q == expected);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a coincident start in IDLE.
    if (abort) begin
      state_d = StIdle;
      misr_d  = misr_q;
      pass_d  = 1'b0;
      vpipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      vpipe_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      vpipe_q <= vpipe_d;
      pass_q  <= pass_d;
    end
  end

endmodule
